// File: rtl/daq_pkg.sv
// Shared constants for the DAQ readout path.
// Slot ids are NSLOT_LOG2 bits wide and wrap modulo the slot count.
package daq_pkg;

  localparam int NSLOT_LOG2 = 6;
  localparam int NSLOT      = 1 << NSLOT_LOG2;
  localparam int SLOT_WORDS = 1023;
  localparam int ROW_LOG2   = 9;
  localparam int LEN_W      = 10;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SLOT_WORDS);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FILL  = 2'd1,
    W_TRUNC = 2'd2
  } wstate_e;

endpackage

// File: rtl/daq_slot_ram.sv
// Simple dual-port RAM with a two-stage registered read.
// The clear only zeroes the read pipeline, never the array.
module daq_slot_ram #(
  parameter int DW = 64,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      rd_q    <= '0;
      rdata_o <= '0;
    end else begin
      rd_q    <= mem_q[raddr_i];
      rdata_o <= rd_q;
    end
  end

endmodule

// File: rtl/daq_readout_buffer.sv
// 64-slot readout store: packs 32-bit words into 64-bit slot rows,
// records slot lengths and frees slots in order.
module daq_readout_buffer
  import daq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [8:0]  nreadouts_available,
  output logic [5:0]  r_buf_id,
  input  logic [5:0]  pick_buf_id,
  output logic [9:0]  buf_len,
  input  logic [9:0]  r_ptr,
  output logic [63:0] data_from_buffer,
  input  logic        done_with_buffer,
  output logic [15:0] status
);

  logic clr;
  assign clr = reset | ~enable;

  wstate_e                 wstate_q, wstate_d;
  logic [LEN_W-1:0]        wc_q, wc_d, cnt_nx;
  logic [31:0]             hold_q, hold_d;
  logic [NSLOT_LOG2-1:0]   w_id_q, r_id_q;
  logic [NSLOT_LOG2:0]     occ_q, occ_d;
  logic                    err_uf_q, err_tr_q;
  logic [7:0]              tc_q;

  logic        full, accept, free, uflow;
  logic        complete, trunc_hit, dwe;
  logic [63:0] dwdata;

  assign full   = (occ_q == (NSLOT_LOG2+1)'(NSLOT));
  assign accept = in_valid & in_ready & ~clr;
  assign free   = done_with_buffer & (occ_q != '0);
  assign uflow  = done_with_buffer & (occ_q == '0);
  assign cnt_nx = wc_q + LEN_W'(1);

  // wc_q is the index of the word being accepted; it is 0 in W_IDLE.
  always_comb begin
    wstate_d  = wstate_q;
    wc_d      = wc_q;
    hold_d    = hold_q;
    dwe       = 1'b0;
    dwdata    = {32'h0, in_data};
    complete  = 1'b0;
    trunc_hit = 1'b0;
    unique case (wstate_q)
      W_IDLE, W_FILL: begin
        if (accept) begin
          if (wc_q[0]) begin
            dwe    = 1'b1;
            dwdata = {in_data, hold_q};
          end else begin
            hold_d = in_data;
            dwe    = in_last | (cnt_nx == LEN_MAX);
          end
          if (in_last) begin
            complete = 1'b1;
            wstate_d = W_IDLE;
            wc_d     = '0;
          end else if (cnt_nx == LEN_MAX) begin
            complete  = 1'b1;
            trunc_hit = 1'b1;
            wstate_d  = W_TRUNC;
            wc_d      = '0;
          end else begin
            wstate_d = W_FILL;
            wc_d     = cnt_nx;
          end
        end
      end
      W_TRUNC: begin
        if (accept && in_last) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({complete, free})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wstate_q <= W_IDLE;
      wc_q     <= '0;
      hold_q   <= '0;
      w_id_q   <= '0;
      r_id_q   <= '0;
      occ_q    <= '0;
      err_uf_q <= 1'b0;
      err_tr_q <= 1'b0;
      tc_q     <= '0;
    end else begin
      wstate_q <= wstate_d;
      wc_q     <= wc_d;
      hold_q   <= hold_d;
      occ_q    <= occ_d;
      if (complete) w_id_q <= w_id_q + 1'b1;
      if (free)     r_id_q <= r_id_q + 1'b1;
      if (uflow)    err_uf_q <= 1'b1;
      if (trunc_hit) begin
        err_tr_q <= 1'b1;
        if (tc_q != 8'hff) tc_q <= tc_q + 8'd1;
      end
    end
  end

  daq_slot_ram #(
    .DW(64),
    .AW(NSLOT_LOG2 + ROW_LOG2)
  ) u_data_ram (
    .clk     (clk),
    .clr_i   (clr),
    .we_i    (dwe),
    .waddr_i ({w_id_q, wc_q[9:1]}),
    .wdata_i (dwdata),
    .raddr_i ({pick_buf_id, r_ptr[9:1]}),
    .rdata_o (data_from_buffer)
  );

  daq_slot_ram #(
    .DW(LEN_W),
    .AW(NSLOT_LOG2)
  ) u_len_ram (
    .clk     (clk),
    .clr_i   (clr),
    .we_i    (complete),
    .waddr_i (w_id_q),
    .wdata_i (cnt_nx),
    .raddr_i (pick_buf_id),
    .rdata_o (buf_len)
  );

  logic unused_rptr0;
  assign unused_rptr0 = r_ptr[0];

  assign in_ready            = clr | ~full;
  assign nreadouts_available = {2'b00, occ_q};
  assign r_buf_id            = r_id_q;
  assign status = {tc_q, err_uf_q, err_tr_q, wstate_q, full, 3'b000};

endmodule

// File: tb/tb_daq_readout_buffer.sv
// Bench for daq_readout_buffer: reference model of slots and occupancy,
// read scoreboard, constant read vectors for the first readout.
module tb_daq_readout_buffer;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [8:0]  nreadouts_available;
  logic [5:0]  r_buf_id, pick_buf_id;
  logic [9:0]  buf_len, r_ptr;
  logic [63:0] data_from_buffer;
  logic        done_with_buffer;
  logic [15:0] status;

  always #5 clk = ~clk;

  daq_readout_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .nreadouts_available (nreadouts_available),
    .r_buf_id            (r_buf_id),
    .pick_buf_id         (pick_buf_id),
    .buf_len             (buf_len),
    .r_ptr               (r_ptr),
    .data_from_buffer    (data_from_buffer),
    .done_with_buffer    (done_with_buffer),
    .status              (status)
  );

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model
  logic [31:0] mword [0:63][0:1023];
  logic [9:0]  mlen  [0:63];
  int m_wid, m_rid, m_occ, m_wc, m_tc;
  bit m_trunc, m_uf, m_tr;

  task automatic model_reset();
    m_wid = 0; m_rid = 0; m_occ = 0; m_wc = 0; m_tc = 0;
    m_trunc = 0; m_uf = 0; m_tr = 0;
  endtask

  task automatic model_cycle(input bit comp, input bit done);
    bit fr;
    fr = done && (m_occ != 0);
    if (done && m_occ == 0) m_uf = 1;
    if (fr) m_rid = (m_rid + 1) % 64;
    m_occ = m_occ + int'(comp) - int'(fr);
  endtask

  task automatic model_accept(input logic [31:0] d, input bit last,
                              input bit done);
    bit comp;
    comp = 0;
    if (!m_trunc) begin
      mword[m_wid][m_wc] = d;
      m_wc++;
      if (last || m_wc == 1023) begin
        mlen[m_wid] = 10'(m_wc);
        if (!last) begin
          m_trunc = 1; m_tr = 1;
          if (m_tc < 255) m_tc++;
        end
        comp = 1;
        m_wid = (m_wid + 1) % 64;
        m_wc = 0;
      end
    end else if (last) begin
      m_trunc = 0;
    end
    model_cycle(comp, done);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [1:0]  ms;
    logic [15:0] est;
    ms  = m_trunc ? 2'd2 : (m_wc != 0 ? 2'd1 : 2'd0);
    est = {8'(m_tc), m_uf, m_tr, ms, (m_occ == 64), 3'b000};
    chk({tag, ".avail"}, 64'(nreadouts_available), 64'(m_occ));
    chk({tag, ".r_buf_id"}, 64'(r_buf_id), 64'(m_rid));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_occ != 64));
    chk({tag, ".status"}, 64'(status), 64'(est));
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0; done_with_buffer = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    model_reset();
  endtask

  task automatic send_word(input logic [31:0] d, input bit last,
                           input bit done);
    int waited;
    waited = 0;
    in_data = d; in_last = last; in_valid = 1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      nchk++;
      $display("FAIL send_timeout: in_ready %b required 1", in_ready);
      in_valid = 0; in_last = 0;
      return;
    end
    done_with_buffer = done;
    tick();
    model_accept(d, last, done);
    in_valid = 0; in_last = 0; done_with_buffer = 0;
  endtask

  task automatic send_readout(input int n, input logic [31:0] base,
                              input bit done_last);
    for (int i = 0; i < n; i++)
      send_word(base + 32'(i), i == n - 1, done_last && (i == n - 1));
  endtask

  task automatic done_pulse();
    done_with_buffer = 1;
    tick();
    done_with_buffer = 0;
    model_cycle(0, 1);
  endtask

  // read scoreboard: an entry is compared two edges after it is issued
  typedef struct packed {
    logic [5:0]  slot;
    logic [9:0]  ptr;
    logic [63:0] d;
    logic [9:0]  l;
  } rd_exp_t;
  rd_exp_t sbq[$];

  task automatic rd_pop();
    rd_exp_t e;
    e = sbq.pop_front();
    chk($sformatf("rd_data s%0d p%0d", e.slot, e.ptr),
        data_from_buffer, e.d);
    chk($sformatf("rd_len s%0d", e.slot), 64'(buf_len), 64'(e.l));
  endtask

  task automatic rd_issue(input logic [5:0] s, input logic [9:0] p,
                          input logic [63:0] d, input logic [9:0] l);
    rd_exp_t e;
    pick_buf_id = s; r_ptr = p;
    e.slot = s; e.ptr = p; e.d = d; e.l = l;
    sbq.push_back(e);
    tick();
    if (sbq.size() == 2) rd_pop();
  endtask

  task automatic rd_drain();
    tick();
    if (sbq.size() == 1) rd_pop();
  endtask

  function automatic logic [63:0] exp_row(input int s, input int p);
    int lo, hi;
    logic [31:0] hw;
    lo = p & ~1;
    hi = p | 1;
    hw = (hi < int'(mlen[s])) ? mword[s][hi] : 32'h0;
    return {hw, mword[s][lo]};
  endfunction

  task automatic read_rows(input int s, input int p0, input int n);
    for (int k = 0; k < n; k++)
      rd_issue(6'(s), 10'(p0 + k), exp_row(s, p0 + k), mlen[s]);
    rd_drain();
  endtask

  task automatic read_slot(input int s);
    for (int p = 0; p < int'(mlen[s]); p += 2)
      rd_issue(6'(s), 10'(p), exp_row(s, p), mlen[s]);
    rd_drain();
  endtask

  typedef struct {
    logic [5:0]  pick;
    logic [9:0]  ptr;
    logic [63:0] data;
    logic [9:0]  len;
  } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{6'd0, 10'd0, 64'hA0000002_A0000001, 10'd5};
    vt[1] = '{6'd0, 10'd2, 64'hA0000004_A0000003, 10'd5};
    vt[2] = '{6'd0, 10'd4, 64'h00000000_A0000005, 10'd5};
    vt[3] = '{6'd0, 10'd1, 64'hA0000002_A0000001, 10'd5};
    vt[4] = '{6'd0, 10'd5, 64'h00000000_A0000005, 10'd5};
    vt[5] = '{6'd0, 10'd3, 64'hA0000004_A0000003, 10'd5};

    reset = 1; enable = 1;
    in_data = 0; in_valid = 0; in_last = 0;
    pick_buf_id = 0; r_ptr = 0; done_with_buffer = 0;
    model_reset();
    tick(); tick(); tick();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.avail", 64'(nreadouts_available), 64'd0);
    chk("rst.buf_len", 64'(buf_len), 64'd0);
    chk("rst.data", data_from_buffer, 64'd0);
    chk("rst.status", 64'(status), 64'd0);
    reset = 0;

    // five-word readout and constant read vectors
    for (int i = 1; i <= 5; i++)
      send_word(32'hA000_0000 + 32'(i), i == 5, 0);
    check_state("t1");
    for (int i = 0; i < 6; i++)
      rd_issue(vt[i].pick, vt[i].ptr, vt[i].data, vt[i].len);
    rd_drain();

    // fill all 64 slots, then stall a 65th readout
    do_reset();
    for (int s = 0; s < 64; s++)
      send_readout(2, 32'hB000_0000 + 32'(s << 4), 0);
    check_state("full");
    in_data = 32'hDEAD_BEEF; in_last = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("full.stall_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 0; in_last = 0;
    check_state("full.hold");
    done_pulse();
    check_state("full.free");
    read_slot(63);
    read_slot(1);

    // complete and free in the same cycle, then wrap ids
    do_reset();
    for (int s = 0; s < 3; s++)
      send_readout(3, 32'hC000_0000 + 32'(s << 4), 0);
    check_state("both.pre");
    send_readout(2, 32'hC100_0000, 1);
    check_state("both");
    read_slot(3);
    for (int i = 0; i < 70; i++)
      send_readout(1 + (i % 4), 32'hD000_0000 + 32'(i << 12), 1);
    check_state("wrap");
    read_slot(0);
    read_slot(8);
    read_slot(9);

    // truncation of an 1100-word readout
    do_reset();
    for (int i = 0; i < 1100; i++) begin
      send_word(32'hE000_0000 + 32'(i), i == 1099, 0);
      if (i == 1049) check_state("trunc.mid");
    end
    check_state("trunc");
    read_rows(0, 0, 4);
    read_rows(0, 1016, 8);
    send_readout(4, 32'hF000_0000, 0);
    check_state("trunc.next");
    read_slot(1);

    // underflow, then enable low clears state
    do_reset();
    done_pulse();
    check_state("uflow");
    enable = 0;
    tick();
    enable = 1;
    model_reset();
    check_state("enable_clr");

    // reset mid-readout
    do_reset();
    for (int i = 0; i < 7; i++)
      send_word(32'h7000_0000 + 32'(i), 0, 0);
    check_state("mid.fill");
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    check_state("mid.rst");
    send_readout(3, 32'h3300_0000, 0);
    check_state("mid.next");
    read_slot(0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/daq_readout_buffer.md
Name: daq_readout_buffer

Overview:
- 64-slot readout store feeding daq_dma_manager. Captures each readout as a 32-bit word stream into its own buffer slot and records the slot length.
- Publishes the completed-readout count and the oldest-slot id.
- Serves random-access 64-bit reads of any slot, and frees slots in order on done_with_buffer.

Parameters:
- NSLOT_LOG2, 6, log2 of slot count; fixed at 6 because slot ids are 6-bit and wrap mod 64.
- SLOT_WORDS, 1023, maximum 32-bit words per readout; a slot spans 512 64-bit RAM rows.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  low = hold in reset state, same as reset.
- in_data  in  32  readout word.
- in_valid  in  1  in_data valid.
- in_last  in  1  final word of readout.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- nreadouts_available  out  9  completed, unfreed readouts, 0..64.
- r_buf_id  out  6  oldest completed slot.
- pick_buf_id  in  6  slot selected for length and data read.
- buf_len  out  10  length of pick_buf_id in 32-bit words.
- r_ptr  in  10  32-bit word address in slot; bit 0 ignored.
- data_from_buffer  out  64  {word[r_ptr|1], word[r_ptr&~1]} of pick_buf_id.
- done_with_buffer  in  1  one-cycle pulse; frees slot r_buf_id.
- status  out  16  {trunc_count[7:0], err_underflow, err_trunc, wstate[1:0], full, 3'b0}.

Behaviour:
- Reset/!enable: w_buf_id=0, r_buf_id=0, occupancy=0, wstate=W_IDLE, error flags and trunc_count cleared. Outputs: in_ready=1, nreadouts_available=0, buf_len=0, data_from_buffer=0.
- Storage: data RAM 64b x (64*512), address {slot, r_ptr[9:1]}. Length RAM 10b x 64.
- Read latency: data_from_buffer is exactly 2 clk after r_ptr/pick_buf_id; buf_len is exactly 2 clk after pick_buf_id. Both registered; no enable on the read path.
- Write packing: even word -> low half of holding reg; odd word -> write {odd, even} row.
  - in_last on an even word -> write {32'h0, even}.
  - Row index = word_count[9:1].
- Write FSM states:
  - W_IDLE: first accepted word -> W_FILL, word_count=1.
  - W_FILL: each accepted word increments word_count. Accept with in_last -> write length RAM[w_buf_id]=word_count (incl. last word), w_buf_id+=1 mod 64, complete pulse, back to W_IDLE.
  - W_FILL, word_count reaches 1023 without last -> W_TRUNC. Stored length = 1023. Slot is completed at the moment of the last accepted word: length written, slot committed. err_trunc set (sticky), trunc_count+=1 (saturating at 255).
  - W_TRUNC: words accepted and discarded until in_last, then W_IDLE.
  - A one-word readout (in_last on first word) completes directly from W_IDLE with length 1.
- Commit visibility: completed slot is counted in occupancy 1 clk after the completing word. Its data row is readable by then.
- in_ready = (occupancy != 64). Occupancy cannot rise mid-readout except by that readout's own completion, so no mid-readout stall is needed. W_TRUNC also obeys in_ready.
- Free: done_with_buffer && occupancy!=0 -> r_buf_id+=1 mod 64, occupancy-=1.
- Free with occupancy==0: ignored, err_underflow sticky.
- Simultaneous complete and free: occupancy unchanged, both ids advance.
- nreadouts_available = occupancy, registered; r_buf_id registered.
- Reading a slot that is not committed returns stale data. This is not checked; the consumer only picks r_buf_id .. r_buf_id+avail-1.
- full = (occupancy==64).

Decomposition:
- Shared package daq_pkg: NSLOT_LOG2, SLOT_WORDS, and the W_IDLE/W_FILL/W_TRUNC state constants (2-bit). The manager and this block share NSLOT_LOG2.
- One sub-module: daq_slot_ram, a simple dual-port RAM with 64-bit write port, 64-bit read port and 2-stage registered read. It is instantiated twice: data (64b x 32768) and length (10b x 64, write data zero-extended).

Test Plan:
- Reset, then a 5-word readout A1..A5 -> avail=1, r_buf_id=0. pick=0 gives buf_len=5 two clk later. r_ptr 0/2/4 gives {A2,A1}, {A4,A3}, {0,A5}.
- 64 readouts of 2 words, no frees -> avail=64, in_ready=0 while a 65th word is presented, and the word is not accepted. One done_with_buffer -> avail=63, r_buf_id=1, in_ready=1.
- Complete and done_with_buffer in the same cycle at avail=3 -> avail stays 3, w_buf_id and r_buf_id both +1. Wrap: 70 write/free pairs -> ids wrap 63->0, and data from slot 0 after wrap is the new readout.
- 1100-word readout without intermediate last -> buf_len=1023, err_trunc=1, trunc_count=1. Words 1024..1100 dropped. The next readout starts at the following slot with correct length.
- done_with_buffer at avail=0 -> avail stays 0, r_buf_id unchanged, err_underflow=1.
- Reset asserted mid-readout at word 7 -> avail=0, in_ready=1, wstate=W_IDLE. The next 3-word readout lands in slot 0 with buf_len=3.
